// File: rtl/fx_chain_scheduler.sv
// Per-sample effect-chain sequencer: grants my_turn to each enabled effect slot in
// order, threads the running sample through them, and emits the result to the DAC.
module fx_chain_scheduler #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_FX     = 3,
    parameter int TIMEOUT    = 255,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         sample_valid,
    input  logic [DATA_WIDTH-1:0]        sample_in,
    input  logic [NUM_FX-1:0]            fx_cs,
    input  logic [NUM_FX-1:0]            fx_available,
    input  logic [NUM_FX-1:0]            fx_done,
    input  logic [NUM_FX*DATA_WIDTH-1:0] fx_data_out,
    output logic [NUM_FX-1:0]            fx_my_turn,
    output logic [DATA_WIDTH-1:0]        fx_data_in,
    output logic [DATA_WIDTH-1:0]        out_sample,
    output logic                         out_valid,
    output logic                         busy,
    output logic                         overrun,
    output logic [NUM_FX-1:0]            timeout_err
);
    localparam int IDX_W = $clog2(NUM_FX + 1);
    localparam int SEL_W = (NUM_FX > 1) ? $clog2(NUM_FX) : 1;
    localparam logic [IDX_W-1:0]     IDX_END   = IDX_W'(NUM_FX);
    // The watchdog fires on the edge where the count would reach TIMEOUT.
    localparam logic [CNT_WIDTH-1:0] WDOG_LAST = CNT_WIDTH'(TIMEOUT - 1);

    typedef enum logic [2:0] {S_IDLE, S_SELECT, S_ISSUE, S_WAIT, S_OUTPUT} state_t;

    state_t                 state_q;
    logic [DATA_WIDTH-1:0]  acc_q;
    logic [DATA_WIDTH-1:0]  out_sample_q;
    logic [IDX_W-1:0]       idx_q;
    logic [IDX_W-1:0]       idx_d;
    logic [CNT_WIDTH-1:0]   wdog_q;
    logic [CNT_WIDTH-1:0]   wdog_d;
    logic [NUM_FX-1:0]      my_turn_q;
    logic [NUM_FX-1:0]      timeout_err_q;
    logic                   out_valid_q;
    logic                   busy_q;
    logic                   overrun_q;
    logic [SEL_W-1:0]       slot;
    logic [NUM_FX-1:0]      slot_onehot;
    logic [DATA_WIDTH-1:0]  fx_result [NUM_FX];
    logic                   wdog_expired;

    assign slot         = idx_q[SEL_W-1:0];
    assign idx_d        = idx_q + 1'b1;
    assign wdog_d       = wdog_q + 1'b1;
    assign wdog_expired = (wdog_q == WDOG_LAST);

    for (genvar gi = 0; gi < NUM_FX; gi++) begin : g_slot
        assign slot_onehot[gi] = (slot == SEL_W'(gi));
        assign fx_result[gi]   = fx_data_out[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            acc_q         <= '0;
            out_sample_q  <= '0;
            idx_q         <= '0;
            wdog_q        <= '0;
            my_turn_q     <= '0;
            timeout_err_q <= '0;
            out_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            my_turn_q     <= '0;
            timeout_err_q <= '0;
            out_valid_q   <= 1'b0;
            overrun_q     <= sample_valid && (state_q != S_IDLE);
            case (state_q)
                S_IDLE: begin
                    if (sample_valid) begin
                        acc_q   <= sample_in;
                        idx_q   <= '0;
                        wdog_q  <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_SELECT;
                    end
                end
                S_SELECT: begin
                    if (idx_q == IDX_END) begin
                        out_sample_q <= acc_q;
                        out_valid_q  <= 1'b1;
                        state_q      <= S_OUTPUT;
                    end else if (!fx_cs[slot]) begin
                        idx_q <= idx_d;
                    end else if (fx_available[slot]) begin
                        wdog_q    <= '0;
                        my_turn_q <= slot_onehot;
                        state_q   <= S_ISSUE;
                    end else if (wdog_expired) begin
                        timeout_err_q <= slot_onehot;
                        idx_q         <= idx_d;
                        wdog_q        <= '0;
                    end else begin
                        wdog_q <= wdog_d;
                    end
                end
                S_ISSUE: begin
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    // A slot that never answers is skipped with acc untouched.
                    if (fx_done[slot]) begin
                        acc_q   <= fx_result[slot];
                        idx_q   <= idx_d;
                        wdog_q  <= '0;
                        state_q <= S_SELECT;
                    end else if (wdog_expired) begin
                        timeout_err_q <= slot_onehot;
                        idx_q         <= idx_d;
                        wdog_q        <= '0;
                        state_q       <= S_SELECT;
                    end else begin
                        wdog_q <= wdog_d;
                    end
                end
                S_OUTPUT: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign fx_my_turn  = my_turn_q;
    assign fx_data_in  = acc_q;
    assign out_sample  = out_sample_q;
    assign out_valid   = out_valid_q;
    assign busy        = busy_q;
    assign overrun     = overrun_q;
    assign timeout_err = timeout_err_q;
endmodule

// File: tb/tb_fx_chain_scheduler.sv
// Self-checking bench for fx_chain_scheduler: behavioural effect models drive the slots,
// a transaction-level reference predicts grants, timeouts and output samples.
`timescale 1ns/1ps
module tb_fx_chain_scheduler;
    localparam int DW  = 16;
    localparam int NFX = 3;
    localparam int TMO = 255;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                sample_valid = 1'b0;
    logic [DW-1:0]       sample_in = '0;
    logic [NFX-1:0]      fx_cs = '0;
    logic [NFX-1:0]      fx_available = '0;
    logic [NFX-1:0]      fx_done = '0;
    logic [NFX*DW-1:0]   fx_data_out = '0;
    logic [NFX-1:0]      fx_my_turn;
    logic [NFX-1:0]      timeout_err;
    logic [DW-1:0]       fx_data_in;
    logic [DW-1:0]       out_sample;
    logic                out_valid;
    logic                busy;
    logic                overrun;

    int total = 0;
    int bad   = 0;

    // Effect behaviour and test configuration.
    logic [DW-1:0]  coef [NFX];
    int             lat  [NFX];
    logic [NFX-1:0] never_done  = '0;
    logic [NFX-1:0] never_avail = '0;
    bit             rand_avail  = 1'b0;
    bit             sv_inject   = 1'b0;
    logic           exp_ov_q;
    logic [DW-1:0]  last_out = '0;
    int             out_count = 0;
    int             ov_seen   = 0;
    bit             prev_ov   = 1'b0;

    // Expected event queues for the transaction in flight.
    int             q_slot [$];
    logic [DW-1:0]  q_val  [$];
    logic [NFX-1:0] q_tmo  [$];
    logic [DW-1:0]  q_out  [$];

    bit             pend     [NFX];
    int             pend_cnt [NFX];
    logic [DW-1:0]  pend_val [NFX];

    fx_chain_scheduler #(
        .DATA_WIDTH(DW), .NUM_FX(NFX), .TIMEOUT(TMO), .CNT_WIDTH(8)
    ) dut (
        .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample_in(sample_in),
        .fx_cs(fx_cs), .fx_available(fx_available), .fx_done(fx_done),
        .fx_data_out(fx_data_out), .fx_my_turn(fx_my_turn), .fx_data_in(fx_data_in),
        .out_sample(out_sample), .out_valid(out_valid), .busy(busy),
        .overrun(overrun), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endfunction

    function automatic logic [DW-1:0] fx_func(int i, logic [DW-1:0] v);
        case (i)
            0:       return v + coef[0];
            1:       return (v << 1) + coef[1];
            default: return v - coef[2];
        endcase
    endfunction

    // Reference: walk the enabled slots in order and fold the effect functions.
    function automatic void push_expect(logic [DW-1:0] s);
        logic [DW-1:0] v;
        v = s;
        for (int i = 0; i < NFX; i++) begin
            if (fx_cs[i]) begin
                if (never_avail[i]) begin
                    q_tmo.push_back(NFX'(1) << i);
                end else begin
                    q_slot.push_back(i);
                    q_val.push_back(v);
                    if (never_done[i]) q_tmo.push_back(NFX'(1) << i);
                    else               v = fx_func(i, v);
                end
            end
        end
        q_out.push_back(v);
    endfunction

    function automatic void flush();
        q_slot.delete(); q_val.delete(); q_tmo.delete(); q_out.delete();
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) exp_ov_q <= 1'b0;
        else      exp_ov_q <= sample_valid & sv_inject;
    end

    // Effect models: done lat cycles after my_turn, result computed from the latched input.
    always @(negedge clk) begin
        for (int i = 0; i < NFX; i++) begin
            if (!rst) begin
                pend[i]    = 1'b0;
                fx_done[i] = 1'b0;
            end else begin
                fx_done[i] = 1'b0;
                fx_data_out[i*DW +: DW] = DW'($urandom);
                if (pend[i]) begin
                    check("wait_data_in_stable", fx_data_in, pend_val[i]);
                    pend_cnt[i]--;
                    if (pend_cnt[i] == 0) begin
                        fx_done[i] = 1'b1;
                        fx_data_out[i*DW +: DW] = fx_func(i, pend_val[i]);
                        pend[i] = 1'b0;
                    end
                end else if (!fx_cs[i] && $urandom_range(0, 7) == 0) begin
                    fx_done[i] = 1'b1;
                end
                if (fx_my_turn[i] && !never_done[i]) begin
                    pend[i]     = 1'b1;
                    pend_cnt[i] = lat[i];
                    pend_val[i] = fx_data_in;
                end
                fx_available[i] = never_avail[i] ? 1'b0
                                : (rand_avail ? ($urandom_range(0, 3) != 0) : 1'b1);
            end
        end
    end

    // Compare process: checks every observable event against the expected queues.
    always @(negedge clk) begin
        if (rst) begin
            check("overrun", overrun, exp_ov_q);
            if (overrun) ov_seen++;
            if (fx_my_turn != '0) begin
                check("busy_at_issue", busy, 1);
                if (q_slot.size() == 0) check("unexpected_my_turn", fx_my_turn, 0);
                else begin
                    check("my_turn_slot", fx_my_turn, NFX'(1) << q_slot[0]);
                    check("issue_data_in", fx_data_in, q_val[0]);
                    void'(q_slot.pop_front());
                    void'(q_val.pop_front());
                end
            end
            if (timeout_err != '0) begin
                if (q_tmo.size() == 0) check("unexpected_timeout", timeout_err, 0);
                else begin
                    check("timeout_slot", timeout_err, q_tmo[0]);
                    void'(q_tmo.pop_front());
                end
            end
            if (out_valid) begin
                out_count++;
                last_out = out_sample;
                check("out_busy", busy, 1);
                check("out_valid_single", prev_ov, 0);
                if (q_out.size() == 0) check("unexpected_out_valid", out_valid, 0);
                else begin
                    check("out_sample", out_sample, q_out[0]);
                    void'(q_out.pop_front());
                end
            end
            prev_ov = out_valid;
        end else begin
            prev_ov = 1'b0;
        end
    end

    task automatic send(logic [DW-1:0] v);
        @(negedge clk);
        sample_in = v; sample_valid = 1'b1; sv_inject = 1'b0;
        push_expect(v);
        @(posedge clk); #1;
        sample_valid = 1'b0;
    endtask

    task automatic inject(logic [DW-1:0] v);
        @(negedge clk);
        sample_in = v; sample_valid = 1'b1; sv_inject = 1'b1;
        @(posedge clk); #1;
        sample_valid = 1'b0; sv_inject = 1'b0;
    endtask

    task automatic wait_out(int budget);
        int n;
        n = 0;
        @(posedge clk); #2;
        while (q_out.size() != 0 && n < budget) begin
            @(posedge clk); #2;
            n++;
        end
        if (q_out.size() != 0) begin
            check("txn_timeout", q_out.size(), 0);
            flush();
        end
        check("pending_issue", q_slot.size(), 0);
        check("pending_tmo", q_tmo.size(), 0);
        check("idle_busy", busy, 0);
    endtask

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "global timeout");
    end

    initial begin
        int n;
        int oc;
        int os;
        for (int i = 0; i < NFX; i++) begin
            coef[i] = '0;
            lat[i]  = 1;
        end

        // Reset values.
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {fx_my_turn, fx_data_in, out_sample, out_valid, busy, overrun, timeout_err}, 0);
        @(negedge clk) rst = 1'b1;

        // All slots bypassed: fixed latency, bit-exact passthrough.
        fx_cs = 3'b000;
        send(16'h1234);
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("bypass_latency", n, NFX + 1);
        check("bypass_out", out_sample, 16'h1234);
        wait_out(100);

        // Single effect, +0x0100, done 3 cycles after my_turn.
        fx_cs = 3'b001; coef[0] = 16'h0100; lat[0] = 3;
        send(16'h0200);
        wait_out(200);
        check("single_fx_out", last_out, 16'h0300);

        // Full chain +1, *2, -3.
        fx_cs = 3'b111; coef[0] = 16'd1; coef[1] = 16'd0; coef[2] = 16'd3;
        lat[0] = 2; lat[1] = 4; lat[2] = 1;
        send(16'd10);
        wait_out(200);
        check("chain_out", last_out, 16'd19);

        // Slot 1 never answers: watchdog skip measured from the grant.
        fx_cs = 3'b010; never_done = 3'b010;
        send(16'hFFF0);
        n = 0;
        while (fx_my_turn == '0 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("wait_tmo_grant", fx_my_turn, 3'b010);
        n = 0;
        while (timeout_err == '0 && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        check("wait_tmo_cycles", n, TMO + 1);
        wait_out(400);
        check("wait_tmo_out", last_out, 16'hFFF0);
        never_done = '0;

        // Slot 2 never becomes available.
        fx_cs = 3'b100; never_avail = 3'b100;
        send(16'h5A5A);
        wait_out(600);
        check("select_tmo_out", last_out, 16'h5A5A);
        never_avail = '0;

        // Second sample while busy is dropped.
        fx_cs = 3'b001; coef[0] = 16'h0011; lat[0] = 20;
        oc = out_count; os = ov_seen;
        send(16'h1000);
        repeat (5) @(posedge clk);
        inject(16'hDEAD);
        wait_out(300);
        check("overrun_out_count", out_count - oc, 1);
        check("overrun_pulses", ov_seen - os, 1);
        check("overrun_out", last_out, 16'h1011);

        // Overrun landing on the output cycle itself.
        fx_cs = 3'b000;
        os = ov_seen;
        send(16'h0F0F);
        repeat (NFX + 1) @(posedge clk);
        inject(16'hBEEF);
        wait_out(100);
        check("overrun_on_output", ov_seen - os, 1);
        check("overrun_on_output_out", last_out, 16'h0F0F);

        // Asynchronous reset in the middle of WAIT.
        fx_cs = 3'b001; lat[0] = 100;
        send(16'h4444);
        n = 0;
        while (fx_my_turn == '0 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check("midrun_reset", {fx_my_turn, fx_data_in, out_sample, out_valid, busy, overrun, timeout_err}, 0);
        flush();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        fx_cs = 3'b000;
        send(16'h8000);
        wait_out(100);
        check("after_reset_out", last_out, 16'h8000);

        // Randomised traffic.
        rand_avail = 1'b1;
        for (int t = 0; t < 120; t++) begin
            @(negedge clk);
            fx_cs = NFX'($urandom);
            for (int i = 0; i < NFX; i++) begin
                coef[i]        = DW'($urandom);
                lat[i]         = $urandom_range(1, 8);
                never_done[i]  = ($urandom_range(0, 19) == 0);
                never_avail[i] = ($urandom_range(0, 19) == 0);
            end
            send(DW'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(0, NFX + 1)) @(posedge clk);
                inject(DW'($urandom));
            end
            wait_out(3000);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fx_chain_scheduler.md
Name: fx_chain_scheduler

Overview:
- Sequences the per-sample effect chain (echo, chorus, ...) between the audio ADC side and the DAC side.
- On each new input sample, grants `my_turn` to each enabled effect in fixed order and chains each effect's `data_out` into the next effect's `data_in`.
- Presents the final processed sample to the audio output with a one-cycle valid strobe.
- Guarantees only one effect is active at a time, so effects never contend for the shared smart_ram port.

Parameters:
- DATA_WIDTH, 16, sample width in bits (two's complement)
- NUM_FX, 3, number of effect slots; slot 0 is processed first
- TIMEOUT, 255, max cycles spent waiting on one effect (for `available` or `done`) before that effect is skipped
- CNT_WIDTH, 8, watchdog counter width; must satisfy 2^CNT_WIDTH > TIMEOUT

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- sample_valid  in  1  one-cycle strobe: new ADC sample on sample_in
- sample_in  in  DATA_WIDTH  raw input sample
- fx_cs  in  NUM_FX  per-slot enable from configuration; also wired to each effect's cs
- fx_available  in  NUM_FX  per-slot `available` (effect is in PASSIVE)
- fx_done  in  NUM_FX  per-slot `done` (one-cycle pulse)
- fx_data_out  in  NUM_FX*DATA_WIDTH  per-slot result; slot i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- fx_my_turn  out  NUM_FX  one-hot `my_turn` grant to the effects
- fx_data_in  out  DATA_WIDTH  shared data_in bus to all effects
- out_sample  out  DATA_WIDTH  processed sample to the DAC side
- out_valid  out  1  one-cycle strobe: out_sample is new
- busy  out  1  high whenever the FSM is not IDLE
- overrun  out  1  one-cycle pulse: sample_valid arrived while busy; that sample is dropped
- timeout_err  out  NUM_FX  one-cycle pulse on the bit of the slot skipped by the watchdog

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, idx=0, acc=0, wdog=0. All outputs are 0, including out_sample and fx_data_in.
- Registered state: acc (DATA_WIDTH), idx (covers 0..NUM_FX), wdog (CNT_WIDTH), FSM state. All outputs are registered; fx_data_in always equals acc.
- IDLE:
  - On sample_valid=1: acc<=sample_in, idx<=0, wdog<=0, go to SELECT.
- SELECT:
  - If idx==NUM_FX: go to OUTPUT.
  - Else if fx_cs[idx]==0: bypass; idx<=idx+1, stay in SELECT. Costs one cycle per disabled slot.
  - Else if fx_available[idx]==1: wdog<=0, go to ISSUE.
  - Else: wdog<=wdog+1. If wdog==TIMEOUT, pulse timeout_err[idx], idx<=idx+1, wdog<=0, acc unchanged.
- ISSUE:
  - fx_my_turn[idx]=1 for exactly this one cycle; all other bits are 0.
  - Go to WAIT.
- WAIT:
  - fx_my_turn=0; acc and fx_data_in are held stable.
  - If fx_done[idx]=1: acc<=fx_data_out[idx], idx<=idx+1, wdog<=0, go to SELECT.
  - Else wdog increments. At wdog==TIMEOUT: pulse timeout_err[idx], acc unchanged (the slot acts as a bypass), idx<=idx+1, go to SELECT.
  - fx_done bits of other slots are ignored.
- OUTPUT:
  - out_sample<=acc, out_valid=1 for this single cycle, go to IDLE.
  - out_sample holds its value until the next OUTPUT.
- Overrun: sample_valid in any state other than IDLE pulses overrun for one cycle. This includes the OUTPUT cycle. The sample is discarded and the current sample's processing is unaffected.
- fx_cs change mid-sample:
  - Sampled only in SELECT.
  - Clearing fx_cs[idx] while in WAIT does not abort; the scheduler still waits for done or timeout.
- Latency:
  - All slots disabled: out_valid rises NUM_FX+1 clocks after the edge that captures sample_valid.
  - Each enabled slot adds 2 cycles (SELECT->ISSUE->WAIT) plus its my_turn-to-done latency.
- Arithmetic: no arithmetic on samples. acc is passed through bit-exact, with no saturation or truncation.
- Reset mid-operation: immediately returns to IDLE with all outputs 0. A my_turn pulse in flight is cut; effects recover via their own reset.

Test Plan:
- Reset, fx_cs=000, sample_in=16'h1234 -> out_valid exactly NUM_FX+1=4 clocks after capture; out_sample=16'h1234; fx_my_turn never asserted.
- fx_cs=001; effect-0 model returns data_in+16'h0100 with done 3 cycles after my_turn; sample_in=16'h0200 -> single my_turn[0] pulse; fx_data_in=16'h0200 stable until done; out_sample=16'h0300.
- fx_cs=111; models return +1, *2, -3 respectively; sample_in=16'd10 -> my_turn order 001,010,100, never overlapping; out_sample=16'd19.
- fx_cs=010; slot-1 model never asserts done, TIMEOUT=255 -> timeout_err=010 pulse 255 cycles after entering WAIT; out_sample equals sample_in (16'hFFF0 passthrough).
- While busy with fx_cs=001 and a slow effect, a second sample_valid arrives -> overrun one-cycle pulse; first sample still completes correctly; exactly one out_valid.
- rst dropped low during WAIT -> all outputs 0 asynchronously; after release, a new sample 16'h8000 with fx_cs=000 -> out_sample=16'h8000.
